// File: rtl/pmp_scan_checker.sv
// pmp_scan_checker: sequential PMP permission checker, one PMP entry per cycle.
// Optional build macro: PMP_CONST_LATENCY_EN -- scan every entry regardless of
// where the first hit is, so response latency does not reveal the hit index.

// NA4 matcher: 4-byte region at addr_n versus request bytes [addr, last].
module pmp_na4_match (
    input  logic [31:0] addr,
    input  logic [32:0] last,
    input  logic [31:0] addr_n,
    output logic        full_c,
    output logic        overlap_c
);
    logic [32:0] region_top;

    assign region_top = {1'b0, addr_n} + 33'd3;
    assign full_c     = (addr >= addr_n) && (last <= region_top);
    assign overlap_c  = ({1'b0, addr} <= region_top) && (last >= {1'b0, addr_n});
endmodule

module pmp_scan_checker #(
    parameter int unsigned NUM_ENTRIES = 16,
    parameter int unsigned IDX_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic [1:0]       req_type,
    input  logic [1:0]       req_priv,
    output logic [IDX_W-1:0] entry_idx,
    input  logic [7:0]       entry_cfg,
    input  logic [31:0]      entry_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_allow,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_idx
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned EXT_W  = 36;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] A_OFF   = 2'd0;
    localparam logic [1:0] A_TOR   = 2'd1;
    localparam logic [1:0] A_NA4   = 2'd2;
    localparam logic [1:0] A_NAPOT = 2'd3;

    localparam logic [1:0] PRIV_M   = 2'd3;
    localparam logic [1:0] PRIV_RSV = 2'd2;
    localparam logic [1:0] TYPE_RSV = 2'd3;

    // Registered state
    logic [1:0]        state;
    logic [ADDR_W-1:0] prev_top;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [1:0]        type_q;
    logic [1:0]        priv_q;

    // Next-state values
    logic [1:0]        state_d;
    logic [IDX_W-1:0]  entry_idx_d;
    logic [ADDR_W-1:0] prev_top_d;
    logic [ADDR_W-1:0] addr_d;
    logic [1:0]        size_d;
    logic [1:0]        type_d;
    logic [1:0]        priv_d;
    logic              req_ready_d;
    logic              resp_valid_d;
    logic              resp_allow_d;
    logic              resp_hit_d;
    logic [IDX_W-1:0]  resp_idx_d;

`ifdef PMP_CONST_LATENCY_EN
    logic              found_q;
    logic              found_allow_q;
    logic [IDX_W-1:0]  found_idx_q;
    logic              found_d;
    logic              found_allow_d;
    logic [IDX_W-1:0]  found_idx_d;
`endif

    // Per-entry evaluation
    logic [ADDR_W-1:0] ent_base;
    logic [1:0]        ent_mode;
    logic [32:0]       req_last;
    logic              req_wrap;
    logic              last_entry;

    logic              na4_full;
    logic              na4_overlap;

    logic              tor_valid;
    logic              tor_full;
    logic              tor_overlap;

    logic [5:0]        napot_k;
    logic [EXT_W-1:0]  napot_len;
    logic [EXT_W-1:0]  napot_base;
    logic [EXT_W-1:0]  napot_top;
    logic [EXT_W-1:0]  req_first_ext;
    logic [EXT_W-1:0]  req_last_ext;
    logic              napot_full;
    logic              napot_overlap;

    logic              match_full;
    logic              match_overlap;
    logic              ent_hit;
    logic              perm_ok;
    logic              ent_allow;
    logic              nohit_allow;

    logic              unused_bits;

    assign unused_bits = ^{entry_cfg[6:5], entry_addr[31:30]};

    // Count trailing ones of a pmpaddr value (NAPOT size encoding)
    function automatic logic [5:0] trailing_ones(input logic [31:0] v);
        logic [5:0] n;
        logic       run;
        n   = 6'd0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && v[i]) begin
                n = n + 6'd1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    assign ent_base   = {entry_addr[29:0], 2'b00};
    assign ent_mode   = entry_cfg[4:3];
    assign req_last   = {1'b0, addr_q} + 33'(size_q);
    assign req_wrap   = req_last[32];
    assign last_entry = (entry_idx == IDX_W'(NUM_ENTRIES - 1));

    pmp_na4_match u_na4 (
        .addr      (addr_q),
        .last      (req_last),
        .addr_n    (ent_base),
        .full_c    (na4_full),
        .overlap_c (na4_overlap)
    );

    // TOR region is [prev_top, ent_base); empty when ent_base <= prev_top
    always_comb begin
        tor_valid   = (ent_base > prev_top);
        tor_full    = tor_valid && (addr_q >= prev_top) && (req_last < {1'b0, ent_base});
        tor_overlap = tor_valid && (addr_q < ent_base) && (req_last >= {1'b0, prev_top});
    end

    // NAPOT region, computed wide so 2^32-byte and larger regions stay exact
    always_comb begin
        napot_k       = trailing_ones(entry_addr);
        napot_len     = EXT_W'(1) << (napot_k + 6'd3);
        napot_base    = {4'b0000, ent_base} & ~(napot_len - EXT_W'(1));
        napot_top     = napot_base + napot_len - EXT_W'(1);
        req_first_ext = {4'b0000, addr_q};
        req_last_ext  = {3'b000, req_last};
        napot_full    = (req_first_ext >= napot_base) && (req_last_ext <= napot_top);
        napot_overlap = (req_first_ext <= napot_top) && (req_last_ext >= napot_base);
    end

    // Select the matcher for the current entry's address mode
    always_comb begin
        match_full    = 1'b0;
        match_overlap = 1'b0;
        case (ent_mode)
            A_TOR: begin
                match_full    = tor_full;
                match_overlap = tor_overlap;
            end
            A_NA4: begin
                match_full    = na4_full;
                match_overlap = na4_overlap;
            end
            A_NAPOT: begin
                match_full    = napot_full;
                match_overlap = napot_overlap;
            end
            default: begin
                match_full    = 1'b0;
                match_overlap = 1'b0;
            end
        endcase
        if (req_wrap) begin
            match_full    = 1'b0;
            match_overlap = 1'b0;
        end
    end

    // Allow/deny decision for a hit on the current entry, and for no hit
    always_comb begin
        ent_hit = match_overlap;
        case (type_q)
            2'd0:    perm_ok = entry_cfg[0];
            2'd1:    perm_ok = entry_cfg[1];
            2'd2:    perm_ok = entry_cfg[2];
            default: perm_ok = 1'b0;
        endcase
        ent_allow   = match_full && (priv_q != PRIV_RSV) && (type_q != TYPE_RSV) &&
                      ((!entry_cfg[7] && (priv_q == PRIV_M)) || perm_ok);
        nohit_allow = (priv_q == PRIV_M) && (type_q != TYPE_RSV) && !req_wrap;
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        entry_idx_d  = entry_idx;
        prev_top_d   = prev_top;
        addr_d       = addr_q;
        size_d       = size_q;
        type_d       = type_q;
        priv_d       = priv_q;
        resp_allow_d = resp_allow;
        resp_hit_d   = resp_hit;
        resp_idx_d   = resp_idx;
`ifdef PMP_CONST_LATENCY_EN
        found_d       = found_q;
        found_allow_d = found_allow_q;
        found_idx_d   = found_idx_q;
`endif

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d      = req_addr;
                    size_d      = req_size;
                    type_d      = req_type;
                    priv_d      = req_priv;
                    entry_idx_d = '0;
                    prev_top_d  = '0;
`ifdef PMP_CONST_LATENCY_EN
                    found_d       = 1'b0;
                    found_allow_d = 1'b0;
                    found_idx_d   = '0;
`endif
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                prev_top_d = ent_base;
`ifdef PMP_CONST_LATENCY_EN
                if (ent_hit && !found_q) begin
                    found_d       = 1'b1;
                    found_allow_d = ent_allow;
                    found_idx_d   = entry_idx;
                end
                if (last_entry) begin
                    resp_hit_d   = found_d;
                    resp_allow_d = found_d ? found_allow_d : nohit_allow;
                    resp_idx_d   = found_d ? found_idx_d : '0;
                    state_d      = RESP;
                end else begin
                    entry_idx_d = entry_idx + IDX_W'(1);
                end
`else
                if (ent_hit) begin
                    resp_hit_d   = 1'b1;
                    resp_allow_d = ent_allow;
                    resp_idx_d   = entry_idx;
                    state_d      = RESP;
                end else if (last_entry) begin
                    resp_hit_d   = 1'b0;
                    resp_allow_d = nohit_allow;
                    resp_idx_d   = '0;
                    state_d      = RESP;
                end else begin
                    entry_idx_d = entry_idx + IDX_W'(1);
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            entry_idx  <= '0;
            prev_top   <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            type_q     <= '0;
            priv_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_allow <= 1'b0;
            resp_hit   <= 1'b0;
            resp_idx   <= '0;
`ifdef PMP_CONST_LATENCY_EN
            found_q       <= 1'b0;
            found_allow_q <= 1'b0;
            found_idx_q   <= '0;
`endif
        end else begin
            state      <= state_d;
            entry_idx  <= entry_idx_d;
            prev_top   <= prev_top_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            type_q     <= type_d;
            priv_q     <= priv_d;
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            resp_allow <= resp_allow_d;
            resp_hit   <= resp_hit_d;
            resp_idx   <= resp_idx_d;
`ifdef PMP_CONST_LATENCY_EN
            found_q       <= found_d;
            found_allow_q <= found_allow_d;
            found_idx_q   <= found_idx_d;
`endif
        end
    end

endmodule
